// File: rtl/right_shift_reg_if.sv
// Bus bundle for right_shift_reg: parallel load, shift enable, serial MSB input and register contents.
interface right_shift_reg_if #(
    parameter int unsigned DW = 4
);
    logic          load;
    logic          en;
    logic [DW-1:0] data;
    logic          data_h;
    logic [DW-1:0] q;

    modport master (
        output load,
        output en,
        output data,
        output data_h,
        input  q
    );

    modport slave (
        input  load,
        input  en,
        input  data,
        input  data_h,
        output q
    );
endinterface

// File: rtl/right_shift_reg.sv
// Parallel-load right-shift register; serial bit enters at the MSB, LSB falls off.
// Priority per edge: reset, then load, then shift, else hold.
module right_shift_reg #(
    parameter int unsigned DW = 4
) (
    input  logic            clk,
    input  logic            sync_rst_n,
    right_shift_reg_if.slave bus
);
    logic [DW-1:0] q_r;
    logic [DW-1:0] shifted_c;

    // A single-bit register has no upper bits to keep, so a shift is just a capture.
    generate
        if (DW == 1) begin : g_w1
            assign shifted_c = bus.data_h;
        end else begin : g_wn
            assign shifted_c = {bus.data_h, q_r[DW-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            q_r <= '0;
        end else if (bus.load) begin
            q_r <= bus.data;
        end else if (bus.en) begin
            q_r <= shifted_c;
        end
    end

    assign bus.q = q_r;
endmodule

// File: tb/tb_right_shift_reg.sv
// Randomised and directed bench for right_shift_reg (DW=4 and DW=1) against an arithmetic reference model.
module tb_right_shift_reg;
    localparam int unsigned DW = 4;

    logic clk;
    logic sync_rst_n;

    right_shift_reg_if #(.DW(DW)) bus4 ();
    right_shift_reg_if #(.DW(1))  bus1 ();

    right_shift_reg #(.DW(DW)) dut4 (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .bus        (bus4)
    );

    right_shift_reg #(.DW(1)) dut1 (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .bus        (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass;
    int unsigned n_total;
    int unsigned model4;
    int unsigned model1;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the register value, shift = divide by two plus MSB insert.
    function automatic int unsigned next_val(input int unsigned cur, input int unsigned width,
                                             input bit rst_n, input bit ld, input bit shift_en,
                                             input int unsigned d, input bit dh);
        int unsigned mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (!rst_n)        return 0;
        else if (ld)       return d & mask;
        else if (shift_en) return ((cur / 2) + (dh ? (32'd1 << (width - 1)) : 32'd0)) & mask;
        else               return cur;
    endfunction

    // One clock: update both models from the inputs seen at the edge, check both DUTs,
    // then re-randomise the DW=1 instance so it runs its own random traffic throughout.
    task automatic tick(input string tag);
        @(posedge clk);
        model4 = next_val(model4, DW, sync_rst_n, bus4.load, bus4.en, 32'(bus4.data), bus4.data_h);
        model1 = next_val(model1, 1, sync_rst_n, bus1.load, bus1.en, 32'(bus1.data), bus1.data_h);
        #1;
        check_eq(tag, 32'(bus4.q), model4);
        check_eq({tag, "_w1"}, 32'(bus1.q), model1);
        bus1.load   = ($urandom_range(0, 3) == 0);
        bus1.en     = 1'($urandom_range(0, 1));
        bus1.data   = 1'($urandom_range(0, 1));
        bus1.data_h = 1'($urandom_range(0, 1));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        model4  = 0;
        model1  = 0;

        sync_rst_n  = 1'b0;
        bus4.load   = 1'b1;
        bus4.en     = 1'b1;
        bus4.data   = 4'hF;
        bus4.data_h = 1'b1;
        bus1.load   = 1'b1;
        bus1.en     = 1'b1;
        bus1.data   = 1'b1;
        bus1.data_h = 1'b1;
        #2;

        // Reset wins over load and shift
        tick("reset");
        check_eq("reset_const", 32'(bus4.q), 32'h0);
        sync_rst_n = 1'b1;

        // Load then hold while data inputs wander
        bus4.load = 1'b1; bus4.en = 1'b0; bus4.data = 4'hA;
        tick("load_a");
        check_eq("load_a_const", 32'(bus4.q), 32'hA);
        bus4.load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus4.data   = 4'($urandom_range(0, 15));
            bus4.data_h = 1'($urandom_range(0, 1));
            tick("hold_a");
            check_eq("hold_a_const", 32'(bus4.q), 32'hA);
        end
        bus4.load = 1'b1; bus4.data = 4'h3;
        tick("load_3");
        check_eq("load_3_const", 32'(bus4.q), 32'h3);

        // Load beats shift
        bus4.load = 1'b1; bus4.en = 1'b1; bus4.data = 4'h9; bus4.data_h = 1'b1;
        tick("load_prio");
        check_eq("load_prio_const", 32'(bus4.q), 32'h9);

        // Directed shift sequence from 0xC
        bus4.load = 1'b1; bus4.en = 1'b0; bus4.data = 4'hC;
        tick("load_c");
        bus4.load = 1'b0; bus4.en = 1'b1;
        begin
            bit          dh_seq [4];
            int unsigned exp_seq [4];
            dh_seq  = '{1'b1, 1'b0, 1'b1, 1'b1};
            exp_seq = '{32'hE, 32'h7, 32'hB, 32'hD};
            for (int i = 0; i < 4; i++) begin
                bus4.data   = 4'($urandom_range(0, 15));
                bus4.data_h = dh_seq[i];
                tick("shift_seq");
                check_eq("shift_seq_const", 32'(bus4.q), exp_seq[i]);
            end
        end

        // Continuous shifting with a reload every 8 cycles
        bus4.en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus4.load   = ((i % 8) == 0);
            bus4.data   = 4'($urandom_range(0, 15));
            bus4.data_h = 1'($urandom_range(0, 1));
            tick("periodic");
        end

        // Full replacement: after DW shifts, q holds the last DW serial bits, oldest in q[0]
        bus4.load = 1'b0; bus4.en = 1'b1;
        begin
            int unsigned bits_in;
            bits_in = 0;
            for (int i = 0; i < int'(DW); i++) begin
                bus4.data_h = 1'($urandom_range(0, 1));
                bits_in = bits_in | (32'(bus4.data_h) << i);
                tick("replace");
            end
            check_eq("replace_const", 32'(bus4.q), bits_in);
        end

        // Reset in the middle of a shift run, then resume
        for (int i = 0; i < 3; i++) begin
            bus4.data_h = 1'($urandom_range(0, 1));
            tick("pre_rst_shift");
        end
        sync_rst_n = 1'b0; bus4.en = 1'b1; bus4.data_h = 1'b1;
        tick("mid_rst");
        check_eq("mid_rst_const", 32'(bus4.q), 32'h0);
        sync_rst_n = 1'b1; bus4.data_h = 1'b1;
        tick("post_rst");
        check_eq("post_rst_const", 32'(bus4.q), 32'h8);

        // Fully random traffic, including occasional resets
        for (int i = 0; i < 200; i++) begin
            sync_rst_n  = ($urandom_range(0, 19) != 0);
            bus4.load   = ($urandom_range(0, 5) == 0);
            bus4.en     = 1'($urandom_range(0, 1));
            bus4.data   = 4'($urandom_range(0, 15));
            bus4.data_h = 1'($urandom_range(0, 1));
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
